// File: rtl/cnt_seq_monitor.sv
// cnt_seq_monitor: checks a counter stream advances by +1 per sample.
// Tracks legal wraps, sequence errors and loss of lock.
module cnt_seq_monitor #(
  parameter int CNT_W    = 4,
  parameter int WRAP_W   = 8,
  parameter int ERR_W    = 8,
  parameter int LOSS_THR = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              cnt_vld,
  input  logic              clr,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  bad_val
);

  typedef enum logic [1:0] {
    S_SYNC,
    S_LOCK,
    S_LOST
  } state_t;

  localparam logic [3:0] LP_THR = 4'(LOSS_THR);

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_exp;
  logic [3:0]          r_miss;
  logic                r_locked;
  logic                r_wrap_pulse;
  logic [WRAP_W-1:0]   r_wrap_cnt;
  logic                r_err_pulse;
  logic                r_err_sticky;
  logic [ERR_W-1:0]    r_err_cnt;
  logic [CNT_W-1:0]    r_bad;

  logic                w_seed;
  logic                w_eval;
  logic                w_match;
  logic                w_zero;
  logic                w_wrap;
  logic                w_mis;
  logic [3:0]          w_miss_nx;
  logic                w_loss;

  // Sample qualification; clr drops any simultaneous sample.
  assign w_seed    = cnt_vld & ~clr & (r_state == S_SYNC);
  assign w_eval    = cnt_vld & ~clr & (r_state == S_LOCK);
  assign w_match   = (cnt_in == r_exp);
  assign w_zero    = (cnt_in == '0);
  assign w_wrap    = w_eval & w_match & w_zero;
  assign w_mis     = w_eval & ~w_match & ~w_zero;
  assign w_miss_nx = r_miss + 4'd1;
  assign w_loss    = w_mis & (w_miss_nx == LP_THR);

  // Next-state selection: clr returns to SYNC, LOST is sticky.
  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = S_SYNC;
    end else begin
      case (r_state)
        S_SYNC:  if (cnt_vld) w_next = S_LOCK;
        S_LOCK:  if (w_loss)  w_next = S_LOST;
        S_LOST:  w_next = S_LOST;
        default: w_next = S_SYNC;
      endcase
    end
  end

  // State register with registered lock indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_SYNC;
      r_locked <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_locked <= (w_next == S_LOCK);
    end
  end

  // Expected value, miss run, statistics and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exp        <= '0;
      r_miss       <= '0;
      r_wrap_pulse <= 1'b0;
      r_wrap_cnt   <= '0;
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
      r_err_cnt    <= '0;
      r_bad        <= '0;
    end else begin
      r_wrap_pulse <= w_wrap;
      r_err_pulse  <= w_mis;
      if (clr) begin
        r_exp        <= '0;
        r_miss       <= '0;
        r_wrap_cnt   <= '0;
        r_err_sticky <= 1'b0;
        r_err_cnt    <= '0;
        r_bad        <= '0;
      end else begin
        if (w_seed | w_eval) begin
          r_exp <= cnt_in + CNT_W'(1);
        end
        if (w_seed | (w_eval & ~w_mis)) begin
          r_miss <= '0;
        end
        if (w_wrap) begin
          r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
        end
        if (w_mis) begin
          r_miss       <= w_miss_nx;
          r_err_sticky <= 1'b1;
          r_bad        <= cnt_in;
          if (r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
          end
        end
      end
    end
  end

  assign locked     = r_locked;
  assign wrap_pulse = r_wrap_pulse;
  assign wrap_cnt   = r_wrap_cnt;
  assign err_pulse  = r_err_pulse;
  assign err_sticky = r_err_sticky;
  assign err_cnt    = r_err_cnt;
  assign bad_val    = r_bad;

endmodule

// File: tb/tb_cnt_seq_monitor.sv
// tb_cnt_seq_monitor: directed stimulus, per-cycle model compare,
// plus literal expectations at key points.
module tb_cnt_seq_monitor;

  localparam int LOSS_THR = 3;

  logic       clk;
  logic       rst;
  logic [3:0] cnt_in;
  logic       cnt_vld;
  logic       clr;
  logic       locked;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] err_cnt;
  logic [3:0] bad_val;

  int checks;
  int failures;

  cnt_seq_monitor #(
    .CNT_W(4), .WRAP_W(8), .ERR_W(8), .LOSS_THR(LOSS_THR)
  ) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_vld(cnt_vld),
    .clr(clr), .locked(locked), .wrap_pulse(wrap_pulse),
    .wrap_cnt(wrap_cnt), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .bad_val(bad_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  // Model: mode 0=seeking, 1=tracking, 2=lost.
  int m_mode;
  int m_exp;
  int m_miss;
  int n_wrap;
  int n_err;
  int e_bv;
  int e_st;
  int e_wp;
  int e_ep;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_exp <= 0; m_miss <= 0;
      n_wrap <= 0; n_err <= 0; e_bv <= 0;
      e_st <= 0; e_wp <= 0; e_ep <= 0;
    end else begin
      e_wp <= 0;
      e_ep <= 0;
      if (clr) begin
        m_mode <= 0; m_exp <= 0; m_miss <= 0;
        n_wrap <= 0; n_err <= 0; e_bv <= 0; e_st <= 0;
      end else if (cnt_vld && m_mode == 0) begin
        m_mode <= 1;
        m_exp  <= (int'(cnt_in) + 1) % 16;
        m_miss <= 0;
      end else if (cnt_vld && m_mode == 1) begin
        m_exp <= (int'(cnt_in) + 1) % 16;
        if (int'(cnt_in) == m_exp || cnt_in == 0) begin
          m_miss <= 0;
          if (cnt_in == 0 && m_exp == 0) begin
            e_wp   <= 1;
            n_wrap <= n_wrap + 1;
          end
        end else begin
          e_ep   <= 1;
          e_st   <= 1;
          n_err  <= n_err + 1;
          e_bv   <= int'(cnt_in);
          m_miss <= m_miss + 1;
          if (m_miss + 1 == LOSS_THR) m_mode <= 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_locked", int'(locked), (m_mode == 1) ? 1 : 0);
      chk("m_wrap_pulse", int'(wrap_pulse), e_wp);
      chk("m_wrap_cnt", int'(wrap_cnt), n_wrap % 256);
      chk("m_err_pulse", int'(err_pulse), e_ep);
      chk("m_err_sticky", int'(err_sticky), e_st);
      chk("m_err_cnt", int'(err_cnt), (n_err > 255) ? 255 : n_err);
      chk("m_bad_val", int'(bad_val), e_bv);
    end
  end

  task automatic step(input logic v, input logic [3:0] d, input logic c);
    cnt_vld = v;
    cnt_in  = d;
    clr     = c;
    @(posedge clk);
    #2;
    cnt_vld = 1'b0;
    clr     = 1'b0;
  endtask

  initial begin
    int v, m, n;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    cnt_vld = 1'b0;
    cnt_in = '0;
    clr = 1'b0;
    #1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_wrap_cnt", int'(wrap_cnt), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_sticky", int'(err_sticky), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Full count with a wrap
    step(1, 4'd0, 0);
    chk("t1_locked", int'(locked), 1);
    for (int i = 1; i < 16; i++) step(1, 4'(i), 0);
    chk("t1_no_wrap_yet", int'(wrap_pulse), 0);
    step(1, 4'd0, 0);
    chk("t1_wrap_pulse", int'(wrap_pulse), 1);
    step(1, 4'd1, 0);
    chk("t1_wrap_pulse_end", int'(wrap_pulse), 0);
    chk("t1_wrap_cnt", int'(wrap_cnt), 1);
    chk("t1_err_cnt", int'(err_cnt), 0);

    // Single jump
    step(0, 4'd0, 1);
    step(1, 4'd4, 0);
    step(1, 4'd5, 0);
    step(1, 4'd6, 0);
    step(1, 4'd9, 0);
    chk("t2_err_pulse", int'(err_pulse), 1);
    chk("t2_bad_val", int'(bad_val), 9);
    chk("t2_err_cnt", int'(err_cnt), 1);
    chk("t2_sticky", int'(err_sticky), 1);
    chk("t2_locked", int'(locked), 1);
    step(1, 4'd10, 0);
    chk("t2_match_after", int'(err_pulse), 0);
    chk("t2_err_cnt_hold", int'(err_cnt), 1);

    // Upstream restart
    step(0, 4'd0, 1);
    chk("t3_sticky_clr", int'(err_sticky), 0);
    step(1, 4'd2, 0);
    step(1, 4'd3, 0);
    step(1, 4'd4, 0);
    step(1, 4'd0, 0);
    chk("t3_no_err", int'(err_pulse), 0);
    chk("t3_no_wrap", int'(wrap_pulse), 0);
    step(1, 4'd1, 0);
    chk("t3_err_cnt", int'(err_cnt), 0);
    chk("t3_wrap_cnt", int'(wrap_cnt), 0);

    // Loss of lock
    step(1, 4'd2, 0);
    step(1, 4'd7, 0);
    chk("t4_err1", int'(err_pulse), 1);
    step(1, 4'd12, 0);
    step(1, 4'd4, 0);
    chk("t4_err3", int'(err_pulse), 1);
    chk("t4_lost", int'(locked), 0);
    chk("t4_err_cnt", int'(err_cnt), 3);
    step(1, 4'd5, 0);
    chk("t4_ignored", int'(err_pulse), 0);
    chk("t4_bad_hold", int'(bad_val), 4);
    step(1, 4'd6, 0);
    chk("t4_err_cnt_hold", int'(err_cnt), 3);
    step(0, 4'd0, 1);
    chk("t4_clr_err_cnt", int'(err_cnt), 0);
    step(1, 4'd8, 0);
    chk("t4_relock", int'(locked), 1);
    step(1, 4'd9, 0);
    chk("t4_relock_ok", int'(err_pulse), 0);

    // Wrap counter rollover
    step(0, 4'd0, 1);
    step(1, 4'd15, 0);
    for (int k = 0; k < 300; k++)
      for (int i = 0; i < 16; i++) step(1, 4'(i), 0);
    chk("t5_wrap_cnt", int'(wrap_cnt), 44);
    chk("t5_err_none", int'(err_cnt), 0);

    // Error counter saturation
    step(0, 4'd0, 1);
    step(1, 4'd0, 0);
    v = 1;
    for (int k = 0; k < 300; k++) begin
      m = (v + 2) % 16;
      if (m == 0) m = (v + 3) % 16;
      step(1, 4'(m), 0);
      if (k == 299) begin
        chk("t5_sat_pulse", int'(err_pulse), 1);
        chk("t5_sat_cnt", int'(err_cnt), 255);
      end
      n = (m + 1) % 16;
      step(1, 4'(n), 0);
      v = (n + 1) % 16;
    end
    chk("t5_still_locked", int'(locked), 1);

    // clr with a simultaneous sample
    step(1, 4'd5, 1);
    chk("t6_clr_unlock", int'(locked), 0);
    chk("t6_clr_no_err", int'(err_pulse), 0);
    chk("t6_clr_no_wrap", int'(wrap_pulse), 0);
    chk("t6_clr_err_cnt", int'(err_cnt), 0);
    step(1, 4'd9, 0);
    chk("t6_seed", int'(locked), 1);
    chk("t6_seed_no_err", int'(err_pulse), 0);
    step(1, 4'd10, 0);
    step(1, 4'd3, 0);
    chk("t6_pre_rst_err", int'(err_cnt), 1);

    // Asynchronous reset mid-cycle
    #1;
    rst = 1'b1;
    #1;
    chk("t6_arst_locked", int'(locked), 0);
    chk("t6_arst_err_cnt", int'(err_cnt), 0);
    chk("t6_arst_sticky", int'(err_sticky), 0);
    chk("t6_arst_bad", int'(bad_val), 0);
    chk("t6_arst_wrap", int'(wrap_cnt), 0);
    chk("t6_arst_pulse", int'(err_pulse), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    step(0, 4'd0, 0);
    step(0, 4'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cnt_seq_monitor.md
Name: cnt_seq_monitor

Overview:
Downstream consumer of the 4-bit up-counter's `cnt` output. It checks, in hardware, that the count stream advances by exactly +1 per valid sample, with legal wrap 15->0 and legal restart to 0. It counts wrap-arounds, flags and counts sequence errors, and declares loss of lock after repeated mismatches. It sits between the counter and any status/debug logic that needs a trusted event count.

Parameters:
CNT_W, 4, width of monitored count
WRAP_W, 8, width of wrap-around event counter
ERR_W, 8, width of saturating error counter
LOSS_THR, 3, consecutive mismatches in LOCK that force LOST (legal range 1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
cnt_in  input  CNT_W  count value from upstream counter
cnt_vld  input  1  cnt_in holds a new sample this cycle
clr  input  1  synchronous clear of all statistics; forces SYNC
locked  output  1  high while FSM in LOCK
wrap_pulse  output  1  one-cycle pulse on a legal wrap (max->0)
wrap_cnt  output  WRAP_W  number of legal wraps, modulo 2^WRAP_W
err_pulse  output  1  one-cycle pulse on a sequence mismatch
err_sticky  output  1  set on any mismatch; cleared only by rst/clr
err_cnt  output  ERR_W  mismatch count, saturates at all-ones
bad_val  output  CNT_W  cnt_in value of the most recent mismatch

Behaviour:
- Clock and reset: one clock domain (`clk`). `rst` is asynchronous, active-high.
- Reset values: FSM=SYNC; exp=0; miss_run=0; all outputs 0.
- All outputs are registered. Pulses appear the cycle after the sampling edge (latency 1). A pulse lasts exactly one cycle.
- Internal state:
  - exp (CNT_W): expected next value.
  - miss_run (4 bits): consecutive mismatches.
- Arithmetic: exp+1 wraps modulo 2^CNT_W.
- FSM states: SYNC, LOCK, LOST.
- SYNC:
  - locked=0.
  - On cnt_vld: exp<=cnt_in+1, miss_run<=0, go LOCK.
  - No wrap or error evaluation on this seeding sample.
- LOCK:
  - locked=1.
  - On cnt_vld, evaluate in this priority order:
    1. cnt_in==exp and cnt_in==0: legal wrap. wrap_pulse=1, wrap_cnt++, miss_run<=0.
    2. cnt_in==exp (nonzero): normal step. miss_run<=0.
    3. cnt_in==0, exp!=0: legal upstream restart. No error, no wrap, miss_run<=0.
    4. Otherwise mismatch: err_pulse=1, err_sticky<=1, err_cnt++ (saturating), bad_val<=cnt_in, miss_run++. If the new miss_run==LOSS_THR, go LOST.
  - In every case exp<=cnt_in+1 (re-seed on the observed value).
  - No cnt_vld: hold everything.
- LOST:
  - locked=0.
  - cnt_vld samples are ignored: no pulses, no counter updates, no bad_val update.
  - Exit only via clr or rst.
- clr (synchronous):
  - Clears err_sticky, err_cnt, wrap_cnt, bad_val, miss_run and exp.
  - Sets FSM to SYNC and suppresses pulses for that cycle.
  - Has priority over a simultaneous cnt_vld; that sample is dropped and not used for seeding.
- Boundaries:
  - err_cnt at 2^ERR_W-1 stays there; err_pulse still fires.
  - wrap_cnt rolls over from 2^WRAP_W-1 to 0.
  - A mismatch followed by a match resets miss_run, so non-consecutive errors never reach LOST.
  - rst asserted mid-stream returns all state to reset values immediately, without waiting for a clock edge.

Test Plan:
1. Reset, then cnt_vld=1 every cycle with cnt_in=0,1,...,15,0,1 -> locked=1 from cycle 2; exactly one wrap_pulse, on the cycle after 0 is sampled; wrap_cnt=1; err_cnt=0.
2. LOCK with stream 5,6,9,10 -> one err_pulse after 9 is sampled; bad_val=9, err_cnt=1, err_sticky=1, locked stays 1; 10 is accepted as a match.
3. Stream 3,4,0,1 (upstream restart) -> no err_pulse, no wrap_pulse, wrap_cnt unchanged.
4. LOSS_THR=3, stream 2,7,12,4 -> three err_pulses; locked falls to 0 the cycle after 4 is sampled; further samples 5,6 give no pulses; clr -> SYNC; next sample 8 seeds and relocks; err_cnt=0.
5. 300 full 0..15 cycles with WRAP_W=8 -> wrap_cnt=44 (300 mod 256); 300 mismatches with ERR_W=8 and LOSS_THR=15, each mismatch separated by a matching sample -> err_cnt saturates at 255.
6. clr and cnt_vld together in LOCK -> sample dropped, state SYNC, no pulses. rst asserted between clock edges mid-stream -> all outputs 0 before the next edge.
